// File: rtl/entropy_word_packer_pkg.sv
// Shared definitions for the entropy word packer and the que_fiao instantiation
// that consumes its words.
//   ent_state_e      : packer FSM states
//   DEF_WORD_WIDTH   : packed word width (equals que_fiao ENQ_WIDTH)
//   DEF_RCT_CUTOFF   : identical-bit run length that raises the RCT alarm
//   DEF_APT_WINDOW   : APT window length in bits, also the start-up test length
//   DEF_APT_CUTOFF   : reference-bit matches per window that raise the APT alarm
package entropy_pkg;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1,
    ST_ALARM   = 2'd2
  } ent_state_e;

  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_RCT_CUTOFF = 21;
  localparam int DEF_APT_WINDOW = 1024;
  localparam int DEF_APT_CUTOFF = 589;

endpackage

// File: rtl/entropy_word_packer_if.sv
// Word bus between the packer and que_fiao.
//   word_valid : drives que_fiao enque
//   word_data  : drives que_fiao wdata
//   fifo_full  : que_fiao full
// Handshake: a word moves on every rising clock edge where word_valid=1 and
// fifo_full=0. While word_valid=1 and fifo_full=1, word_data is held stable;
// word_valid never drops without a transfer except on reset or a health alarm.
interface entropy_word_packer_if
  import entropy_pkg::*;
#(
  parameter int W = DEF_WORD_WIDTH
);
  logic         word_valid;
  logic [W-1:0] word_data;
  logic         fifo_full;

  modport master (output word_valid, output word_data, input fifo_full);
  modport slave  (input word_valid, input word_data, output fifo_full);
endinterface

// File: rtl/entropy_word_packer_health.sv
// Continuous health tests on the raw bit stream: repetition count (RCT) and
// adaptive proportion (APT).
//   clk, rst     : clock, asynchronous active-high reset
//   i_strobe     : i_bit is a sample to be tested this cycle
//   i_bit        : raw entropy bit
//   i_clear      : restart both tests and drop the alarms
//   o_alarm_rct  : sticky registered RCT alarm
//   o_alarm_apt  : sticky registered APT alarm
//   o_rct_hit    : this strobed bit trips the RCT (alarm visible next cycle)
//   o_apt_hit    : this strobed bit trips the APT (alarm visible next cycle)
//   o_win_done   : this strobed bit is the last one of an APT window
module entropy_health_tests #(
  parameter int RCT_CUTOFF = 21,
  parameter int APT_WINDOW = 1024,
  parameter int APT_CUTOFF = 589
) (
  input  logic clk,
  input  logic rst,
  input  logic i_strobe,
  input  logic i_bit,
  input  logic i_clear,
  output logic o_alarm_rct,
  output logic o_alarm_apt,
  output logic o_rct_hit,
  output logic o_apt_hit,
  output logic o_win_done
);
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int AW = $clog2(APT_WINDOW + 1);
  localparam int WW = $clog2(APT_WINDOW);
  localparam logic [RW-1:0] RCT_MAX  = RW'(RCT_CUTOFF);
  localparam logic [AW-1:0] APT_LIM  = AW'(APT_CUTOFF);
  localparam logic [WW-1:0] WIN_LAST = WW'(APT_WINDOW - 1);

  if (RCT_CUTOFF < 2) begin : g_bad_rct
    $error("RCT_CUTOFF must be at least 2");
  end
  if (APT_CUTOFF > APT_WINDOW) begin : g_bad_apt
    $error("APT_CUTOFF must not exceed APT_WINDOW");
  end

  logic          r_last;
  logic          r_ref;
  logic [RW-1:0] r_rct_cnt;
  logic [AW-1:0] r_apt_cnt;
  logic [WW-1:0] r_win_cnt;
  logic [RW-1:0] w_rct_next;
  logic [AW-1:0] w_apt_next;

  // rct_cnt==0 marks "no previous bit" after reset or clear.
  always_comb begin
    w_rct_next = RW'(1);
    if (r_rct_cnt != '0 && i_bit == r_last)
      w_rct_next = (r_rct_cnt == RCT_MAX) ? r_rct_cnt : r_rct_cnt + 1'b1;
    w_apt_next = r_apt_cnt;
    if (r_win_cnt == '0)
      w_apt_next = AW'(1);
    else if (i_bit == r_ref)
      w_apt_next = r_apt_cnt + 1'b1;
  end

  assign o_rct_hit  = i_strobe && (w_rct_next >= RCT_MAX);
  assign o_apt_hit  = i_strobe && (w_apt_next >= APT_LIM);
  assign o_win_done = i_strobe && (r_win_cnt == WIN_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last      <= 1'b0;
      r_ref       <= 1'b0;
      r_rct_cnt   <= '0;
      r_apt_cnt   <= '0;
      r_win_cnt   <= '0;
      o_alarm_rct <= 1'b0;
      o_alarm_apt <= 1'b0;
    end else if (i_clear) begin
      r_last      <= 1'b0;
      r_ref       <= 1'b0;
      r_rct_cnt   <= '0;
      r_apt_cnt   <= '0;
      r_win_cnt   <= '0;
      o_alarm_rct <= 1'b0;
      o_alarm_apt <= 1'b0;
    end else if (i_strobe) begin
      r_last    <= i_bit;
      r_rct_cnt <= w_rct_next;
      r_apt_cnt <= w_apt_next;
      if (r_win_cnt == '0) r_ref <= i_bit;
      r_win_cnt <= (r_win_cnt == WIN_LAST) ? '0 : r_win_cnt + 1'b1;
      if (o_rct_hit) o_alarm_rct <= 1'b1;
      if (o_apt_hit) o_alarm_apt <= 1'b1;
    end
  end
endmodule

// File: rtl/entropy_word_packer.sv
// Entropy word packer: health-tests a raw bit stream, packs good bits MSB-first
// into words and offers them to que_fiao. Nothing is emitted during start-up
// testing or after a health alarm.
//   clk, rst      : clock, asynchronous active-high reset
//   bit_valid     : bit_in is a new raw sample
//   bit_in        : raw entropy bit
//   clear_alarm   : in ALARM, clear alarms and restart start-up testing
//   fifo          : word_valid / word_data / fifo_full bus to que_fiao
//   ready         : FSM is in RUN
//   alarm_rct     : sticky repetition-count failure
//   alarm_apt     : sticky adaptive-proportion failure
//   overflow      : one-cycle pulse, a completed word was dropped
//   dbg_state     : current FSM state
module entropy_word_packer
  import entropy_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
  parameter int APT_WINDOW = DEF_APT_WINDOW,
  parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bit_valid,
  input  logic                         bit_in,
  input  logic                         clear_alarm,
  entropy_word_packer_if.master        fifo,
  output logic                         ready,
  output logic                         alarm_rct,
  output logic                         alarm_apt,
  output logic                         overflow,
  output ent_state_e                   dbg_state
);
  localparam int BW = $clog2(WORD_WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_WIDTH - 1);

  ent_state_e            r_state;
  logic [WORD_WIDTH-1:0] r_shreg;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_hold_valid;
  logic [WORD_WIDTH-1:0] r_hold_data;
  logic                  r_overflow;

  logic                  w_strobe;
  logic                  w_clear;
  logic                  w_rct_hit;
  logic                  w_apt_hit;
  logic                  w_hit;
  logic                  w_win_done;
  logic                  w_xfer;
  logic [WORD_WIDTH-1:0] w_word;

  // Bits arriving in ALARM (including one alongside clear_alarm) are not tested.
  assign w_strobe = bit_valid && (r_state != ST_ALARM);
  assign w_clear  = clear_alarm && (r_state == ST_ALARM);
  assign w_hit    = w_rct_hit || w_apt_hit;
  assign w_xfer   = r_hold_valid && !fifo.fifo_full;
  assign w_word   = {r_shreg[WORD_WIDTH-2:0], bit_in};

  entropy_health_tests #(
    .RCT_CUTOFF (RCT_CUTOFF),
    .APT_WINDOW (APT_WINDOW),
    .APT_CUTOFF (APT_CUTOFF)
  ) u_health (
    .clk         (clk),
    .rst         (rst),
    .i_strobe    (w_strobe),
    .i_bit       (bit_in),
    .i_clear     (w_clear),
    .o_alarm_rct (alarm_rct),
    .o_alarm_apt (alarm_apt),
    .o_rct_hit   (w_rct_hit),
    .o_apt_hit   (w_apt_hit),
    .o_win_done  (w_win_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_STARTUP;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      // A load later in this block overrides the release on the same edge.
      if (w_xfer) r_hold_valid <= 1'b0;
      case (r_state)
        ST_STARTUP: begin
          if (w_hit)           r_state <= ST_ALARM;
          else if (w_win_done) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_hit) begin
            // The alarm register sets on this same edge, so the held word and
            // the partial word (which holds the failing bit) vanish together.
            r_state      <= ST_ALARM;
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
          end else if (w_strobe) begin
            r_shreg <= w_word;
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
              if (!r_hold_valid || w_xfer) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= w_word;
              end else begin
                r_overflow <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        ST_ALARM: begin
          r_shreg   <= '0;
          r_bit_cnt <= '0;
          if (w_clear) r_state <= ST_STARTUP;
        end
        default: r_state <= ST_STARTUP;
      endcase
    end
  end

  assign fifo.word_valid = r_hold_valid;
  assign fifo.word_data  = r_hold_data;
  assign ready           = (r_state == ST_RUN);
  assign overflow        = r_overflow;
  assign dbg_state       = r_state;
endmodule
